// File: rtl/tx_pulse_ch.sv
// -----------------------------------------------------------------------------
// tx_pulse_ch
// Per-element transmit focusing channel. On start it reads this element's
// focal delay for the selected scan line from a local delay LUT, waits that
// many cycles, then drives a bipolar burst to the pulser. tx_en frames the
// whole event and is the same signal the receive channel uses to gate its
// sample valid.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (LUT contents are kept)
//   lut_addr     delay-LUT write address
//   lut_we       delay-LUT write enable (allowed in every state)
//   lut_din      delay-LUT write data, in clk cycles
//   line_sel     scan line whose delay is read when start is accepted
//   start        begin an event; accepted only in IDLE
//   abort        terminate the event at the next edge without done
//   ch_en        channel enable; 0 times the event but drives no pulses
//   half_period  pulse half-period in cycles (0 behaves as 1)
//   n_cycles     number of full bipolar cycles (0 = no pulses)
//   tx_p, tx_n   positive / negative pulser drive, never both high
//   tx_en        transmit event active
//   busy         FSM not in IDLE
//   done         one-cycle pulse after a normal return to IDLE
// -----------------------------------------------------------------------------
module tx_pulse_ch #(
    parameter int ADDR_WD = 7,
    parameter int DLY_WD  = 12,
    parameter int HP_WD   = 6,
    parameter int NC_WD   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_WD-1:0] lut_addr,
    input  logic               lut_we,
    input  logic [DLY_WD-1:0]  lut_din,
    input  logic [ADDR_WD-1:0] line_sel,
    input  logic               start,
    input  logic               abort,
    input  logic               ch_en,
    input  logic [HP_WD-1:0]   half_period,
    input  logic [NC_WD-1:0]   n_cycles,
    output logic               tx_p,
    output logic               tx_n,
    output logic               tx_en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, FETCH, DELAY, PULSE} state_t;
    typedef enum logic {PH_P, PH_N} phase_t;

    // Delay LUT and its registered read data.
    logic [DLY_WD-1:0] lut_mem [2**ADDR_WD];
    logic [DLY_WD-1:0] rd_data;

    state_t            state, state_nx;
    phase_t            phase, phase_nx;
    logic [DLY_WD-1:0] dly_cnt, dly_cnt_nx;
    logic [HP_WD-1:0]  hp_cnt, hp_cnt_nx;
    logic [NC_WD-1:0]  cyc_cnt, cyc_cnt_nx;
    logic [HP_WD-1:0]  h_q, h_nx;
    logic [NC_WD-1:0]  n_q, n_nx;
    logic              ch_en_q, ch_en_nx;
    logic              done_nx;
    logic              accept;

    assign accept = (state == IDLE) && start && !abort;

    // NOTE: the LUT has no reset branch; clearing a RAM on reset would turn it
    // into flops, and the delay table must survive rst anyway.
    // The read is taken on the accepting edge straight from line_sel, so it
    // captures that scan line's address at start and the data is ready for
    // FETCH. Non-blocking semantics give read-first behaviour on a same-cycle
    // write to the same address.
    always_ff @(posedge clk) begin
        if (lut_we)
            lut_mem[lut_addr] <= lut_din;
        if (accept)
            rd_data <= lut_mem[line_sel];
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        dly_cnt_nx = dly_cnt;
        hp_cnt_nx  = hp_cnt;
        cyc_cnt_nx = cyc_cnt;
        h_nx       = h_q;
        n_nx       = n_q;
        ch_en_nx   = ch_en_q;
        done_nx    = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = FETCH;
                    h_nx     = (half_period == '0) ? HP_WD'(1) : half_period;
                    n_nx     = n_cycles;
                    ch_en_nx = ch_en;
                end
            end
            FETCH: begin
                dly_cnt_nx = rd_data;
                state_nx   = DELAY;
            end
            DELAY: begin
                if (dly_cnt == '0) begin
                    if (n_q == '0) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx   = PULSE;
                        phase_nx   = PH_P;
                        hp_cnt_nx  = h_q - HP_WD'(1);
                        cyc_cnt_nx = n_q;
                    end
                end else begin
                    dly_cnt_nx = dly_cnt - DLY_WD'(1);
                end
            end
            PULSE: begin
                // hp_cnt holds the cycles remaining in the current phase minus one.
                if (hp_cnt == '0) begin
                    hp_cnt_nx = h_q - HP_WD'(1);
                    if (phase == PH_P) begin
                        phase_nx = PH_N;
                    end else if (cyc_cnt == NC_WD'(1)) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        phase_nx   = PH_P;
                        cyc_cnt_nx = cyc_cnt - NC_WD'(1);
                    end
                end else begin
                    hp_cnt_nx = hp_cnt - HP_WD'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort wins over everything, including a normal completion.
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            done_nx  = 1'b0;
        end
    end

    // Outputs are registered from the next-state values so they change on the
    // same edge as the state they describe.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= PH_P;
            dly_cnt <= '0;
            hp_cnt  <= '0;
            cyc_cnt <= '0;
            h_q     <= '0;
            n_q     <= '0;
            ch_en_q <= 1'b0;
            tx_p    <= 1'b0;
            tx_n    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            phase   <= phase_nx;
            dly_cnt <= dly_cnt_nx;
            hp_cnt  <= hp_cnt_nx;
            cyc_cnt <= cyc_cnt_nx;
            h_q     <= h_nx;
            n_q     <= n_nx;
            ch_en_q <= ch_en_nx;
            tx_p    <= (state_nx == PULSE) && (phase_nx == PH_P) && ch_en_nx;
            tx_n    <= (state_nx == PULSE) && (phase_nx == PH_N) && ch_en_nx;
            busy    <= (state_nx != IDLE);
            done    <= done_nx;
        end
    end

    assign tx_en = busy;

endmodule

// File: tb/tb_tx_pulse_ch.sv
// -----------------------------------------------------------------------------
// tb_tx_pulse_ch
// Directed bench for tx_pulse_ch. Expected waveforms come from the closed-form
// event timing (total = 2+D+2HN, tx_p from E(2+D), alternating every H cycles)
// and a shadow copy of the delay LUT kept by the bench.
// -----------------------------------------------------------------------------
module tb_tx_pulse_ch;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  lut_addr;
    logic        lut_we;
    logic [11:0] lut_din;
    logic [6:0]  line_sel;
    logic        start;
    logic        abort;
    logic        ch_en;
    logic [5:0]  half_period;
    logic [3:0]  n_cycles;
    logic        tx_p, tx_n, tx_en, busy, done;

    int checks   = 0;
    int failures = 0;
    int lut_model [128];

    tx_pulse_ch dut (
        .clk         (clk),
        .rst         (rst),
        .lut_addr    (lut_addr),
        .lut_we      (lut_we),
        .lut_din     (lut_din),
        .line_sel    (line_sel),
        .start       (start),
        .abort       (abort),
        .ch_en       (ch_en),
        .half_period (half_period),
        .n_cycles    (n_cycles),
        .tx_p        (tx_p),
        .tx_n        (tx_n),
        .tx_en       (tx_en),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] out_vec();
        return {tx_p, tx_n, tx_en, busy, done};
    endfunction

    // Expected {tx_p, tx_n, tx_en, busy, done} k edges after the accepting edge.
    function automatic logic [4:0] exp_vec(int k, int d, int h, int n, bit en);
        int  total = 2 + d + 2 * h * n;
        bit  on    = (k < total);
        bit  pls   = (k >= 2 + d) && on;
        int  idx   = pls ? (k - 2 - d) / h : 0;
        bit  p     = en && pls && (idx % 2 == 0);
        bit  nn    = en && pls && (idx % 2 == 1);
        return {p, nn, on, on, (k == total)};
    endfunction

    task automatic lut_write(input int addr, input int val);
        @(negedge clk);
        lut_we   = 1'b1;
        lut_addr = 7'(addr);
        lut_din  = 12'(val);
        @(posedge clk);
        #1;
        lut_we = 1'b0;
        lut_model[addr] = val;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Run one event from start through the done cycle. spur_k >= 0 pulses a
    // (to-be-ignored) start at that cycle and, if spur_wr >= 0, rewrites this
    // line's LUT entry there. same_wr >= 0 writes the line in the start cycle.
    task automatic run_event(input string tag, input int line, input int h, input int n,
                             input bit en, input int spur_k, input int spur_wr,
                             input int same_wr);
        int d     = lut_model[line];
        int h_eff = (h == 0) ? 1 : h;
        int total = 2 + d + 2 * h_eff * n;
        @(negedge clk);
        line_sel    = 7'(line);
        half_period = 6'(h);
        n_cycles    = 4'(n);
        ch_en       = en;
        start       = 1'b1;
        if (same_wr >= 0) begin
            lut_we   = 1'b1;
            lut_addr = 7'(line);
            lut_din  = 12'(same_wr);
        end
        for (int k = 0; k <= total; k++) begin
            if (k > 0) @(posedge clk);
            else       @(posedge clk);
            #1;
            start  = 1'b0;
            lut_we = 1'b0;
            // Scramble the per-event inputs; they must have been latched.
            half_period = 6'(h_eff + 2);
            n_cycles    = 4'(n + 1);
            ch_en       = ~en;
            line_sel    = 7'(line + 1);
            check($sformatf("%s k=%0d out", tag, k), 32'(out_vec()), 32'(exp_vec(k, d, h_eff, n, en)));
            check($sformatf("%s k=%0d p&n", tag, k), 32'(tx_p & tx_n), 32'd0);
            if (k == spur_k) begin
                start = 1'b1;
                if (spur_wr >= 0) begin
                    lut_we   = 1'b1;
                    lut_addr = 7'(line);
                    lut_din  = 12'(spur_wr);
                end
            end
        end
        if (same_wr >= 0) lut_model[line] = same_wr;
        if (spur_wr >= 0) lut_model[line] = spur_wr;
    endtask

    // Start an event and kill it at cycle kill_k with abort or rst.
    task automatic kill_event(input string tag, input int line, input int h, input int n,
                              input int kill_k, input bit use_rst);
        int d = lut_model[line];
        @(negedge clk);
        line_sel    = 7'(line);
        half_period = 6'(h);
        n_cycles    = 4'(n);
        ch_en       = 1'b1;
        start       = 1'b1;
        for (int k = 0; k <= kill_k; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check($sformatf("%s k=%0d out", tag, k), 32'(out_vec()), 32'(exp_vec(k, d, h, n, 1'b1)));
        end
        if (use_rst) rst = 1'b1;
        else         abort = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        abort = 1'b0;
        check($sformatf("%s killed", tag), 32'(out_vec()), 32'd0);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s quiet j=%0d", tag, j), 32'(out_vec()), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; lut_addr = '0; lut_we = 1'b0; lut_din = '0; line_sel = '0;
        start = 1'b0; abort = 1'b0; ch_en = 1'b0; half_period = '0; n_cycles = '0;
        foreach (lut_model[i]) lut_model[i] = 0;
        idle(3);
        check("reset outputs", 32'(out_vec()), 32'd0);
        rst = 1'b0;
        idle(1);
        check("idle outputs", 32'(out_vec()), 32'd0);

        // Every line the bench reads is written first.
        lut_write(5, 10);
        lut_write(0, 0);
        lut_write(3, 7);
        lut_write(7, 4095);

        run_event("basic", 5, 3, 2, 1'b1, -1, -1, -1);
        idle(2);
        run_event("d0_h0", 0, 0, 1, 1'b1, -1, -1, -1);
        idle(2);
        run_event("dmax", 7, 0, 1, 1'b1, -1, -1, -1);
        idle(2);
        run_event("n0", 3, 2, 0, 1'b1, -1, -1, -1);
        idle(2);
        run_event("chen0", 3, 2, 3, 1'b0, -1, -1, -1);
        idle(2);
        // Start pulse and LUT rewrite during DELAY: ignored for this event.
        run_event("spur_dly", 5, 2, 1, 1'b1, 5, 30, -1);
        idle(2);
        // Start pulse during PULSE (D=30, pulse from k=32).
        run_event("spur_pls", 5, 2, 2, 1'b1, 35, -1, -1);
        // Back-to-back: each next start lands in the previous done cycle.
        run_event("b2b_a", 0, 1, 1, 1'b1, -1, -1, -1);
        run_event("b2b_b", 3, 1, 2, 1'b1, -1, -1, -1);
        idle(2);
        // Same-cycle write and start on line 5: old value 30 is used.
        run_event("rdfirst", 5, 1, 1, 1'b1, -1, -1, 50);
        idle(2);
        run_event("after_wr", 5, 1, 1, 1'b1, -1, -1, -1);
        idle(2);
        // D=50: pulse starts at k=52; abort mid-burst.
        kill_event("abort", 5, 3, 2, 54, 1'b0);
        run_event("post_abort", 0, 2, 2, 1'b1, -1, -1, -1);
        idle(2);
        kill_event("rst", 5, 1, 1, 10, 1'b1);
        run_event("post_rst", 5, 1, 1, 1'b1, -1, -1, -1);

        for (int r = 0; r < 8; r++) begin
            int line = int'($urandom_range(127, 0));
            lut_write(line, int'($urandom_range(40, 0)));
            run_event($sformatf("rand%0d", r), line, int'($urandom_range(4, 0)),
                      int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
